// File: rtl/alu_slice.sv
// alu_slice: Am2901-style ALU slice, widened to WIDTH bits, with a small
// sequencer that runs iterative unsigned multiply / divide through the
// register file and the Q register.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   nRESET       asynchronous active-low reset
//   I[8:0]       microinstruction: [2:0] source, [5:3] function, [8:6] destination
//   Aadd, Badd   register read / read-write addresses (AW bits)
//   D            external data operand
//   C0           ALU carry in
//   start, mode  begin iterative op (mode 0 = multiply, 1 = divide), sampled when idle
//   Y            data output (reg[P] while an iterative op is running or finishing)
//   C4, OVR      carry out, signed overflow
//   F3, Fz       result MSB, result zero
//   busy, done   op in progress / one-cycle completion pulse
//   dz           divide by zero, held until the next accepted start
module alu_slice #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic [8:0]       I,
    input  logic [AW-1:0]    Aadd,
    input  logic [AW-1:0]    Badd,
    input  logic [WIDTH-1:0] D,
    input  logic             C0,
    input  logic             start,
    input  logic             mode,
    output logic [WIDTH-1:0] Y,
    output logic             C4,
    output logic             OVR,
    output logic             F3,
    output logic             Fz,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // source operand selects
    localparam logic [2:0] SRC_AQ = 3'd0, SRC_AB = 3'd1, SRC_ZQ = 3'd2, SRC_ZB = 3'd3,
                           SRC_ZA = 3'd4, SRC_DA = 3'd5, SRC_DQ = 3'd6;
    // ALU functions
    localparam logic [2:0] FN_ADD = 3'd0, FN_SUBR = 3'd1, FN_SUBS = 3'd2, FN_OR = 3'd3,
                           FN_AND = 3'd4, FN_NOTRS = 3'd5, FN_EXOR = 3'd6;
    // destinations
    localparam logic [2:0] DST_QREG = 3'd0, DST_NOP = 3'd1, DST_RAMA = 3'd2, DST_RAMF = 3'd3,
                           DST_RAMQD = 3'd4, DST_RAMD = 3'd5, DST_RAMQU = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m_reg;
    logic [AW-1:0]    p_reg;
    logic [CW-1:0]    cnt;
    logic             dz_r;

    logic [WIDTH-1:0] a_val, b_val, acc;
    logic [WIDTH-1:0] r, s, r_op, s_op, f;
    logic [WIDTH:0]   sum;
    logic             carry, ovf;
    logic [WIDTH-1:0] y_alu, reg_wd, q_wd;
    logic             reg_we, q_we;
    logic             div_zero;
    logic [WIDTH:0]   mul_sum, div_rem;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign a_val = regs[Aadd];
    assign b_val = regs[Badd];
    assign acc   = regs[p_reg];

    // ---------------- source operand mux ----------------
    always_comb begin
        r = '0;
        s = '0;
        case (I[2:0])
            SRC_AQ: begin r = a_val; s = q;     end
            SRC_AB: begin r = a_val; s = b_val; end
            SRC_ZQ: s = q;
            SRC_ZB: s = b_val;
            SRC_ZA: s = a_val;
            SRC_DA: begin r = D; s = a_val; end
            SRC_DQ: begin r = D; s = q;     end
            default: r = D;                      // DZ
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        r_op  = r;
        s_op  = s;
        sum   = '0;
        f     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (I[5:3])
            FN_ADD, FN_SUBR, FN_SUBS: begin
                if (I[5:3] == FN_SUBR) r_op = ~r;
                if (I[5:3] == FN_SUBS) s_op = ~s;
                sum   = {1'b0, r_op} + {1'b0, s_op} + {{WIDTH{1'b0}}, C0};
                f     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                // overflow judged on the operands actually fed to the adder
                ovf   = (r_op[WIDTH-1] == s_op[WIDTH-1]) && (sum[WIDTH-1] != r_op[WIDTH-1]);
            end
            FN_OR:    f = r | s;
            FN_AND:   f = r & s;
            FN_NOTRS: f = ~r & s;
            FN_EXOR:  f = r ^ s;
            default:  f = ~(r ^ s);              // EXNOR
        endcase
    end

    // ---------------- destination decode (shift-in bits are 0) ----------------
    always_comb begin
        y_alu  = f;
        reg_we = 1'b0;
        reg_wd = f;
        q_we   = 1'b0;
        q_wd   = f;
        case (I[8:6])
            DST_QREG:  q_we = 1'b1;
            DST_NOP:   ;
            DST_RAMA:  begin reg_we = 1'b1; y_alu = a_val; end
            DST_RAMF:  reg_we = 1'b1;
            DST_RAMQD: begin reg_we = 1'b1; reg_wd = f >> 1; q_we = 1'b1; q_wd = q >> 1; end
            DST_RAMD:  begin reg_we = 1'b1; reg_wd = f >> 1; end
            DST_RAMQU: begin reg_we = 1'b1; reg_wd = f << 1; q_we = 1'b1; q_wd = q << 1; end
            default:   begin reg_we = 1'b1; reg_wd = f << 1; end    // RAMU
        endcase
    end

    // ---------------- iterative step datapath ----------------
    assign div_zero = mode && (a_val == '0);
    assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m_reg} : '0);
    // partial remainder after shift; acc < M so it fits in WIDTH+1 bits
    assign div_rem  = {acc, q[WIDTH-1]};
    assign div_ge   = div_rem >= {1'b0, m_reg};
    // difference is < M, so the low WIDTH bits are exact
    assign div_diff = div_rem[WIDTH-1:0] - m_reg;

    // ---------------- sequencer ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = div_zero ? FIN : (mode ? DIV : MUL);
            MUL, DIV: if (cnt == LAST) state_nxt = FIN;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            q     <= '0;
            m_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
            dz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // M is captured before the clear, so Aadd==Badd still works
                        m_reg <= a_val;
                        p_reg <= Badd;
                        cnt   <= '0;
                        dz_r  <= div_zero;
                        if (!div_zero) regs[Badd] <= '0;
                    end else begin
                        if (reg_we) regs[Badd] <= reg_wd;
                        if (q_we)   q <= q_wd;
                    end
                end
                MUL: begin
                    regs[p_reg] <= mul_sum[WIDTH:1];
                    q           <= {mul_sum[0], q[WIDTH-1:1]};
                    cnt         <= cnt + 1'b1;
                end
                DIV: begin
                    regs[p_reg] <= div_ge ? div_diff : div_rem[WIDTH-1:0];
                    q           <= {q[WIDTH-2:0], div_ge};
                    cnt         <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign busy = (state == MUL) || (state == DIV);
    assign done = (state == FIN);
    assign dz   = dz_r;
    assign Y    = (busy || done) ? acc : y_alu;
    assign C4   = carry;
    assign OVR  = ovf;
    assign F3   = f[WIDTH-1];
    assign Fz   = (f == '0);

endmodule

// File: tb/tb_alu_slice.sv
// Bench for alu_slice: a 16-bit instance carries the ALU, multiply, divide
// and reset checks; an 8x4 instance checks that inputs are ignored while busy.
// Multiply/divide expectations come from the bench's own * / % model and are
// queued when the op starts, then popped as the DUT delivers results.
module tb_alu_slice;

    localparam logic [2:0] AQ = 3'd0, AB = 3'd1, ZQ = 3'd2, ZB = 3'd3,
                           ZA = 3'd4, DA = 3'd5, DQ = 3'd6, DZ = 3'd7;
    localparam logic [2:0] F_ADD = 3'd0, F_SUBR = 3'd1, F_SUBS = 3'd2, F_OR = 3'd3,
                           F_AND = 3'd4, F_NOTRS = 3'd5, F_EXOR = 3'd6, F_EXNOR = 3'd7;
    localparam logic [2:0] D_QREG = 3'd0, D_NOP = 3'd1, D_RAMA = 3'd2, D_RAMF = 3'd3,
                           D_RAMQD = 3'd4, D_RAMD = 3'd5, D_RAMQU = 3'd6, D_RAMU = 3'd7;

    function automatic logic [8:0] ins(input logic [2:0] d, input logic [2:0] fn, input logic [2:0] src);
        return {d, fn, src};
    endfunction

    logic        clk = 1'b0;
    logic        nRESET;
    // 16-bit instance
    logic [8:0]  I;
    logic [3:0]  Aadd, Badd;
    logic [15:0] D, Y;
    logic        C0, start, mode, C4, OVR, F3, Fz, busy, done, dz;
    // 8-bit instance
    logic [8:0]  i8;
    logic [1:0]  a8, b8;
    logic [7:0]  d8, y8;
    logic        c08, st8, md8, c48, ovr8, f38, fz8, busy8, done8, dz8;

    always #5 clk = ~clk;

    alu_slice #(.WIDTH(16), .DEPTH(16)) u_dut (
        .clk(clk), .nRESET(nRESET), .I(I), .Aadd(Aadd), .Badd(Badd), .D(D), .C0(C0),
        .start(start), .mode(mode), .Y(Y), .C4(C4), .OVR(OVR), .F3(F3), .Fz(Fz),
        .busy(busy), .done(done), .dz(dz)
    );

    alu_slice #(.WIDTH(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .nRESET(nRESET), .I(i8), .Aadd(a8), .Badd(b8), .D(d8), .C0(c08),
        .start(st8), .mode(md8), .Y(y8), .C4(c48), .OVR(ovr8), .F3(f38), .Fz(fz8),
        .busy(busy8), .done(done8), .dz(dz8)
    );

    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        sb_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [63:0] got);
        sb_t e;
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.tag = "sb_empty";
            e.v   = 'x;
        end
        chk(e.tag, got, e.v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [8:0] i, input int a, input int b, input logic [15:0] d, input logic c);
        I = i; Aadd = 4'(a); Badd = 4'(b); D = d; C0 = c; start = 1'b0;
        #1;
    endtask

    task automatic wr_reg(input int k, input logic [15:0] v);
        drv(ins(D_RAMF, F_ADD, DZ), 0, k, v, 1'b0);
        tick();
    endtask

    task automatic wr_q(input logic [15:0] v);
        drv(ins(D_QREG, F_ADD, DZ), 0, 0, v, 1'b0);
        tick();
    endtask

    task automatic rd_reg(input int k, output logic [15:0] v);
        drv(ins(D_NOP, F_ADD, ZA), k, 0, 16'h0, 1'b0);
        v = Y;
    endtask

    task automatic rd_q(output logic [15:0] v);
        drv(ins(D_NOP, F_ADD, ZQ), 0, 0, 16'h0, 1'b0);
        v = Y;
    endtask

    // Issue start, then count cycles (start edge = cycle 1) until done.
    task automatic run_op(input int a, input int b, input logic md,
                          output int bn, output int dn, output logic [15:0] yd, output logic dzd);
        I = ins(D_NOP, F_ADD, ZA); Aadd = 4'(a); Badd = 4'(b); mode = md; start = 1'b1;
        tick();
        start = 1'b0;
        bn = 0; dn = 0; yd = '0; dzd = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                dn = c; yd = Y; dzd = dz;
                break;
            end
            if (busy) bn++;
            tick();
        end
        tick();   // FIN -> IDLE
    endtask

    task automatic do_op(input int ai, input int bi, input logic md,
                         input logic [15:0] av, input logic [15:0] qv);
        logic [15:0] ehi, elo, v, yd;
        int          bn, dn, edone, ebusy;
        logic        edz, dzd;
        if (ai != bi) wr_reg(bi, 16'hA5A5);
        wr_reg(ai, av);
        wr_q(qv);
        if (!md) begin
            {ehi, elo} = 32'(av) * 32'(qv);
            edone = 17; ebusy = 16; edz = 1'b0;
        end else if (av == 16'h0) begin
            ehi = (ai != bi) ? 16'hA5A5 : 16'h0;
            elo = qv;
            edone = 1; ebusy = 0; edz = 1'b1;
        end else begin
            elo = qv / av;
            ehi = qv % av;
            edone = 17; ebusy = 16; edz = 1'b0;
        end
        sb_push("op_done_cyc", 64'(edone));
        sb_push("op_busy_cyc", 64'(ebusy));
        sb_push("op_y_at_done", 64'(ehi));
        sb_push("op_dz", 64'(edz));
        sb_push("op_reg_p", 64'(ehi));
        sb_push("op_q", 64'(elo));
        run_op(ai, bi, md, bn, dn, yd, dzd);
        sb_pop(64'(dn));
        sb_pop(64'(bn));
        sb_pop(64'(yd));
        sb_pop(64'(dzd));
        rd_reg(bi, v);
        sb_pop(64'(v));
        rd_q(v);
        sb_pop(64'(v));
    endtask

    task automatic drv8(input logic [8:0] i, input int a, input int b, input logic [7:0] d,
                        input logic st, input logic md);
        i8 = i; a8 = 2'(a); b8 = 2'(b); d8 = d; st8 = st; md8 = md;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        int          ndone, dn;

        nRESET = 1'b0;
        I = ins(D_NOP, F_ADD, DZ); Aadd = '0; Badd = '0; D = 16'h00F0; C0 = 1'b0;
        start = 1'b0; mode = 1'b0;
        i8 = ins(D_NOP, F_ADD, ZA); a8 = '0; b8 = '0; d8 = '0; c08 = 1'b0; st8 = 1'b0; md8 = 1'b0;
        repeat (2) tick();

        // ---- reset state: outputs follow live decode over zeroed registers
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(dz),   64'd0);
        chk("rst_y_dz", 64'(Y),    64'h00F0);
        drv(ins(D_NOP, F_ADD, ZA), 7, 0, 16'h0, 1'b0);
        chk("rst_y_za", 64'(Y),    64'h0);
        chk("rst_fz",   64'(Fz),   64'd1);
        nRESET = 1'b1;
        tick();

        // ---- basic add
        wr_reg(3, 16'h1234);
        drv(ins(D_NOP, F_ADD, AB), 3, 3, 16'h0, 1'b0);
        chk("add_y",   64'(Y),   64'h2468);
        chk("add_c4",  64'(C4),  64'd0);
        chk("add_ovr", 64'(OVR), 64'd0);

        // ---- overflow / subtract boundaries
        wr_reg(1, 16'h7FFF);
        wr_reg(2, 16'h0001);
        drv(ins(D_NOP, F_ADD, AB), 1, 2, 16'h0, 1'b0);
        chk("ovf_y",   64'(Y),   64'h8000);
        chk("ovf_ovr", 64'(OVR), 64'd1);
        chk("ovf_f3",  64'(F3),  64'd1);
        chk("ovf_fz",  64'(Fz),  64'd0);
        drv(ins(D_NOP, F_SUBS, ZB), 0, 2, 16'h0, 1'b1);
        chk("subs_y",  64'(Y),   64'hFFFF);
        chk("subs_c4", 64'(C4),  64'd0);
        drv(ins(D_NOP, F_SUBS, AB), 1, 2, 16'h0, 1'b1);
        chk("subs2_y",  64'(Y),  64'h7FFE);
        chk("subs2_c4", 64'(C4), 64'd1);
        drv(ins(D_NOP, F_SUBR, ZB), 0, 2, 16'h0, 1'b0);
        chk("subr_y",  64'(Y),   64'h0000);
        chk("subr_c4", 64'(C4),  64'd1);
        chk("subr_fz", 64'(Fz),  64'd1);
        drv(ins(D_NOP, F_EXOR, AB), 1, 2, 16'h0, 1'b1);
        chk("xor_y",   64'(Y),   64'h7FFE);
        chk("xor_c4",  64'(C4),  64'd0);
        drv(ins(D_NOP, F_NOTRS, DA), 1, 0, 16'h00FF, 1'b0);
        chk("notrs_y", 64'(Y),   64'h7F00);
        drv(ins(D_NOP, F_EXNOR, DQ), 0, 0, 16'h0F0F, 1'b0);
        chk("exnor_y", 64'(Y),   64'hF0F0);

        // ---- destinations
        drv(ins(D_RAMA, F_ADD, DZ), 1, 4, 16'h5555, 1'b0);
        chk("rama_y", 64'(Y), 64'h7FFF);
        tick();
        rd_reg(4, v);  chk("rama_wr", 64'(v), 64'h5555);
        drv(ins(D_NOP, F_ADD, DZ), 0, 4, 16'hFFFF, 1'b0); tick();
        rd_reg(4, v);  chk("nop_nowr", 64'(v), 64'h5555);
        drv(ins(D_RAMD, F_ADD, DZ), 0, 7, 16'h8001, 1'b0); tick();
        rd_reg(7, v);  chk("ramd", 64'(v), 64'h4000);
        drv(ins(D_RAMU, F_ADD, DZ), 0, 7, 16'h8001, 1'b0); tick();
        rd_reg(7, v);  chk("ramu", 64'(v), 64'h0002);
        wr_q(16'h8001);
        drv(ins(D_RAMQD, F_ADD, DZ), 0, 8, 16'h0003, 1'b0); tick();
        rd_q(v);       chk("ramqd_q", 64'(v), 64'h4000);
        rd_reg(8, v);  chk("ramqd_r", 64'(v), 64'h0001);
        drv(ins(D_RAMQU, F_ADD, DZ), 0, 8, 16'h8001, 1'b0); tick();
        rd_q(v);       chk("ramqu_q", 64'(v), 64'h8000);
        rd_reg(8, v);  chk("ramqu_r", 64'(v), 64'h0002);

        // ---- multiply / divide
        do_op(5, 6, 1'b0, 16'hFFFF, 16'hFFFF);
        do_op(5, 6, 1'b1, 16'd7, 16'd1000);
        do_op(5, 6, 1'b1, 16'd0, 16'd142);
        repeat (3) tick();
        chk("dz_hold", 64'(dz), 64'd1);
        do_op(9, 9, 1'b0, 16'd7, 16'd6);          // clears dz, shared address
        do_op(9, 9, 1'b1, 16'd5, 16'd100);
        do_op(5, 6, 1'b1, 16'd1, 16'hFFFF);
        do_op(5, 6, 1'b1, 16'hFFFF, 16'hFFFE);
        for (int k = 0; k < 6; k++)
            do_op(10, 11, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

        // ---- reset in the middle of a multiply
        wr_reg(5, 16'h1234);
        wr_q(16'h5678);
        I = ins(D_NOP, F_ADD, ZA); Aadd = 4'd5; Badd = 4'd6; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        nRESET = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_y",    64'(Y),    64'h0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            if (c == 2) nRESET = 1'b1;
            tick();
        end
        chk("mrst_nodone", 64'(ndone), 64'd0);
        rd_reg(5, v);  chk("mrst_r5", 64'(v), 64'h0);
        rd_reg(6, v);  chk("mrst_r6", 64'(v), 64'h0);
        rd_q(v);       chk("mrst_q",  64'(v), 64'h0);
        do_op(1, 2, 1'b0, 16'd3, 16'd5);

        // ---- 8-bit instance: start and writes ignored while busy
        drv8(ins(D_RAMF, F_ADD, DZ), 0, 1, 8'd13, 1'b0, 1'b0); tick();
        drv8(ins(D_QREG, F_ADD, DZ), 0, 0, 8'd11, 1'b0, 1'b0); tick();
        drv8(ins(D_RAMF, F_ADD, DZ), 0, 3, 8'h33, 1'b0, 1'b0); tick();
        drv8(ins(D_NOP, F_ADD, ZA), 1, 2, 8'h0, 1'b1, 1'b0);   tick();
        drv8(ins(D_RAMF, F_ADD, DZ), 0, 3, 8'hAA, 1'b1, 1'b1);
        dn = 0;
        for (int c = 1; c <= 50; c++) begin
            if (done8) begin
                dn = c;
                break;
            end
            b8 = (c < 5) ? 2'd3 : 2'd2;
            tick();
        end
        drv8(ins(D_NOP, F_ADD, ZA), 0, 0, 8'h0, 1'b0, 1'b0);
        tick();
        chk("w8_done_cyc", 64'(dn), 64'd9);
        drv8(ins(D_NOP, F_ADD, ZQ), 0, 0, 8'h0, 1'b0, 1'b0);
        chk("w8_q", 64'(y8), 64'h8F);
        drv8(ins(D_NOP, F_ADD, ZA), 2, 0, 8'h0, 1'b0, 1'b0);
        chk("w8_hi", 64'(y8), 64'h00);
        drv8(ins(D_NOP, F_ADD, ZA), 3, 0, 8'h0, 1'b0, 1'b0);
        chk("w8_r3", 64'(y8), 64'h33);
        chk("w8_busy", 64'(busy8), 64'd0);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
